// File: rtl/hdr_rx_dec.sv
`default_nettype none
// ============================================================================
// Module      : hdr_rx_dec
// Description : Receive-side packet-header decoder. Collects the 54 raw header
//               bits (18 info bits, each repeated 3x), majority-votes every
//               triplet, de-whitens the voted bit and runs it through the
//               UAP-seeded HEC LFSR. On completion it latches
//               LT_ADDR/TYPE/FLOW/ARQN/SEQN, reports the HEC result and pulses
//               hdr_done_p so the payload bit processor may start.
// Optional    : define HDR_FEC13_ERRCNT_EN to count non-unanimous triplets
//               on fec13_errcnt (tied to 0 otherwise).
// Ports       : clk_6M, rstz (async, active-low)
//               p_1us/rxbit      - received bit strobe and data
//               hdr_st_p         - header start (restarts from any state)
//               whiten_ini       - whitening seed, loaded on hdr_st_p
//               regi_*_UAP, mpr/spr/ir - HEC seed sources and select
//               hdr_lt_addr/type/flow/arqn/seqn - decoded header fields
//               hec_good, hdr_done_p, hdr_busy, fec13_errcnt
// Revision    : 1.0 - initial release
// ============================================================================
module hdr_rx_dec #(
    parameter int HDR_INFO_BITS = 18,
    parameter int FEC_REP       = 3
) (
    input  logic       clk_6M,
    input  logic       rstz,
    input  logic       p_1us,
    input  logic       rxbit,
    input  logic       hdr_st_p,
    input  logic [6:0] whiten_ini,
    input  logic [7:0] regi_paged_BD_ADDR_UAP,
    input  logic [7:0] regi_master_BD_ADDR_UAP,
    input  logic [7:0] regi_my_BD_ADDR_UAP,
    input  logic       mpr,
    input  logic       spr,
    input  logic       ir,
    output logic [2:0] hdr_lt_addr,
    output logic [3:0] hdr_type,
    output logic       hdr_flow,
    output logic       hdr_arqn,
    output logic       hdr_seqn,
    output logic       hec_good,
    output logic       hdr_done_p,
    output logic       hdr_busy,
    output logic [4:0] fec13_errcnt
);

    localparam int                 c_IDX_W     = $clog2(HDR_INFO_BITS + 1);
    localparam int                 c_DATA_BITS = HDR_INFO_BITS - 8;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(HDR_INFO_BITS);
    localparam logic [1:0]         c_TRI_LAST  = 2'(FEC_REP - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RX   = 2'd1,
        S_CHK  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [1:0]             r_tri_cnt;
    logic                   r_b0;
    logic                   r_b1;
    logic [6:0]             r_w;
    logic [7:0]             r_h;
    logic [c_DATA_BITS-1:0] r_sr;
    logic [c_IDX_W-1:0]     r_bit_idx;
    logic [2:0]             r_lt_addr;
    logic [3:0]             r_type;
    logic                   r_flow;
    logic                   r_arqn;
    logic                   r_seqn;
    logic                   r_hec_good;
    logic                   r_done_p;

    logic                   w_maj;
    logic                   w_d;
    logic                   w_fb;
    logic [7:0]             w_seed;
    logic                   w_sample;
    logic                   w_bit_end;

    always_comb begin
        w_maj  = (r_b0 & r_b1) | (r_b0 & rxbit) | (r_b1 & rxbit);
        w_d    = w_maj ^ r_w[6];
        w_fb   = w_d ^ r_h[7];
        w_seed = mpr ? regi_paged_BD_ADDR_UAP :
                 spr ? regi_my_BD_ADDR_UAP    :
                 ir  ? 8'h00                  : regi_master_BD_ADDR_UAP;
        // A start in the same cycle as a strobe drops that strobe; strobes
        // arriving after the last info bit but before CHK are ignored too.
        w_sample  = (r_state == S_RX) && p_1us && !hdr_st_p && (r_bit_idx != c_LAST_IDX);
        w_bit_end = w_sample && (r_tri_cnt == c_TRI_LAST);
    end

    always_comb begin
        w_state_nxt = r_state;
        if (hdr_st_p) begin
            w_state_nxt = S_RX;
        end else begin
            case (r_state)
                S_RX:    if (r_bit_idx == c_LAST_IDX) w_state_nxt = S_CHK;
                S_CHK:   w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            r_tri_cnt  <= 2'd0;
            r_b0       <= 1'b0;
            r_b1       <= 1'b0;
            r_w        <= 7'd0;
            r_h        <= 8'd0;
            r_sr       <= '0;
            r_bit_idx  <= '0;
            r_lt_addr  <= 3'd0;
            r_type     <= 4'd0;
            r_flow     <= 1'b0;
            r_arqn     <= 1'b0;
            r_seqn     <= 1'b0;
            r_hec_good <= 1'b0;
            r_done_p   <= 1'b0;
        end else begin
            r_done_p <= 1'b0;
            if (hdr_st_p) begin
                r_w       <= whiten_ini;
                r_h       <= w_seed;
                r_tri_cnt <= 2'd0;
                r_bit_idx <= '0;
            end else begin
                if (w_sample) begin
                    if (r_tri_cnt == 2'd0) r_b0 <= rxbit;
                    if (r_tri_cnt == 2'd1) r_b1 <= rxbit;
                    if (w_bit_end) begin
                        r_tri_cnt <= 2'd0;
                        // Whitening LFSR D^7+D^4+1, output tap w[6]
                        r_w <= {r_w[5:4], r_w[3] ^ r_w[6], r_w[2:0], r_w[6]};
                        // HEC LFSR D^8+D^7+D^5+D^2+D+1; feeding the received
                        // HEC bits through it leaves 0 for a clean header.
                        r_h <= {r_h[6] ^ w_fb, r_h[5], r_h[4] ^ w_fb, r_h[3:2],
                                r_h[1] ^ w_fb, r_h[0] ^ w_fb, w_fb};
                        // Only the data bits are kept; HEC bits live in r_h.
                        for (int k = 0; k < c_DATA_BITS; k++) begin
                            if (r_bit_idx == c_IDX_W'(k)) r_sr[k] <= w_d;
                        end
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end else begin
                        r_tri_cnt <= r_tri_cnt + 2'd1;
                    end
                end
                if (r_state == S_CHK) begin
                    r_hec_good <= (r_h == 8'd0);
                    r_lt_addr  <= r_sr[2:0];
                    r_type     <= r_sr[6:3];
                    r_flow     <= r_sr[7];
                    r_arqn     <= r_sr[8];
                    r_seqn     <= r_sr[9];
                    r_done_p   <= 1'b1;
                end
            end
        end
    end

`ifdef HDR_FEC13_ERRCNT_EN
    localparam logic [4:0] c_ERR_MAX = 5'(HDR_INFO_BITS);
    logic [4:0] r_errcnt;
    logic       w_split;

    assign w_split = !((r_b0 == r_b1) && (r_b1 == rxbit));

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            r_errcnt <= 5'd0;
        end else if (hdr_st_p) begin
            r_errcnt <= 5'd0;
        end else if (w_bit_end && w_split && (r_errcnt != c_ERR_MAX)) begin
            r_errcnt <= r_errcnt + 5'd1;
        end
    end

    assign fec13_errcnt = r_errcnt;
`else
    assign fec13_errcnt = 5'd0;
`endif

    assign hdr_lt_addr = r_lt_addr;
    assign hdr_type    = r_type;
    assign hdr_flow    = r_flow;
    assign hdr_arqn    = r_arqn;
    assign hdr_seqn    = r_seqn;
    assign hec_good    = r_hec_good;
    assign hdr_done_p  = r_done_p;
    assign hdr_busy    = (r_state == S_RX) || (r_state == S_CHK);

endmodule
`default_nettype wire

// File: tb/tb_hdr_rx_dec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_hdr_rx_dec
// Description : Self-checking bench for hdr_rx_dec. Table vectors for the
//               directed headers, randomized headers against a CRC/whitening
//               reference model, and hand sequences for abort, async reset and
//               start/strobe collision.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdr_rx_dec;

    localparam logic [7:0] UAP_PAGED  = 8'h47;
    localparam logic [7:0] UAP_MASTER = 8'h3C;
    localparam logic [7:0] UAP_MY     = 8'h91;

    logic       clk_6M = 1'b0;
    logic       rstz;
    logic       p_1us;
    logic       rxbit;
    logic       hdr_st_p;
    logic [6:0] whiten_ini;
    logic       mpr, spr, ir;
    logic [2:0] hdr_lt_addr;
    logic [3:0] hdr_type;
    logic       hdr_flow, hdr_arqn, hdr_seqn;
    logic       hec_good, hdr_done_p, hdr_busy;
    logic [4:0] fec13_errcnt;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always #5 clk_6M = ~clk_6M;

    hdr_rx_dec dut (
        .clk_6M                  (clk_6M),
        .rstz                    (rstz),
        .p_1us                   (p_1us),
        .rxbit                   (rxbit),
        .hdr_st_p                (hdr_st_p),
        .whiten_ini              (whiten_ini),
        .regi_paged_BD_ADDR_UAP  (UAP_PAGED),
        .regi_master_BD_ADDR_UAP (UAP_MASTER),
        .regi_my_BD_ADDR_UAP     (UAP_MY),
        .mpr                     (mpr),
        .spr                     (spr),
        .ir                      (ir),
        .hdr_lt_addr             (hdr_lt_addr),
        .hdr_type                (hdr_type),
        .hdr_flow                (hdr_flow),
        .hdr_arqn                (hdr_arqn),
        .hdr_seqn                (hdr_seqn),
        .hec_good                (hec_good),
        .hdr_done_p              (hdr_done_p),
        .hdr_busy                (hdr_busy),
        .fec13_errcnt            (fec13_errcnt)
    );

    always @(negedge clk_6M) if (hdr_done_p) done_cnt <= done_cnt + 1;

    // ---------------- reference model ----------------
    function automatic logic [7:0] hec_seed(input logic m, input logic s, input logic i);
        return m ? UAP_PAGED : s ? UAP_MY : i ? 8'h00 : UAP_MASTER;
    endfunction

    // CRC division step, generator x^8+x^7+x^5+x^2+x+1
    function automatic logic [7:0] crc_step(input logic [7:0] h, input logic d);
        logic [7:0] sh;
        sh = {h[6:0], 1'b0};
        return (h[7] ^ d) ? (sh ^ 8'hA7) : sh;
    endfunction

    // Whitening sequence generator x^7+x^4+1; output bit is w[6]
    function automatic logic [6:0] wh_step(input logic [6:0] w);
        logic [6:0] sh;
        sh = {w[5:0], 1'b0};
        return w[6] ? (sh ^ 7'h11) : sh;
    endfunction

    function automatic logic [53:0] encode(input logic [9:0] data, input logic [6:0] wini,
                                           input logic [7:0] seed);
        logic [17:0] info;
        logic [7:0]  h;
        logic [6:0]  w;
        logic [53:0] tx;
        logic        b;
        h = seed;
        for (int k = 0; k < 10; k++) h = crc_step(h, data[k]);
        info[9:0] = data;
        for (int j = 0; j < 8; j++) info[10+j] = h[7-j];
        w  = wini;
        tx = '0;
        for (int k = 0; k < 18; k++) begin
            b = info[k] ^ w[6];
            w = wh_step(w);
            tx[3*k +: 3] = {3{b}};
        end
        return tx;
    endfunction

    task automatic model_decode(input logic [53:0] bits, input logic [6:0] wini,
                                input logic [7:0] seed, output logic [9:0] fields,
                                output logic good, output logic [4:0] err);
        logic [6:0] w;
        logic [7:0] h;
        logic       d;
        int         votes;
        int         nerr;
        w = wini; h = seed; nerr = 0; fields = '0;
        for (int k = 0; k < 18; k++) begin
            votes = int'(bits[3*k]) + int'(bits[3*k+1]) + int'(bits[3*k+2]);
            if (votes == 1 || votes == 2) nerr++;
            d = (votes >= 2) ^ w[6];
            w = wh_step(w);
            h = crc_step(h, d);
            if (k < 10) fields[k] = d;
        end
        good = (h == 8'd0);
`ifdef HDR_FEC13_ERRCNT_EN
        err = 5'(nerr);
`else
        err = 5'd0;
`endif
    endtask

    // ---------------- stimulus / check helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_hdr(input logic [6:0] wini, input logic m, input logic s,
                             input logic i, input logic collide);
        whiten_ini = wini; mpr = m; spr = s; ir = i;
        hdr_st_p = 1'b1;
        p_1us = collide; rxbit = 1'b1;
        @(negedge clk_6M);
        hdr_st_p = 1'b0; p_1us = 1'b0;
        // seeds must have been captured on the start pulse only
        whiten_ini = 7'($urandom); mpr = 1'($urandom); spr = 1'($urandom); ir = 1'($urandom);
    endtask

    task automatic strobe(input logic b);
        p_1us = 1'b1; rxbit = b;
        @(negedge clk_6M);
        p_1us = 1'b0; rxbit = 1'($urandom);
    endtask

    task automatic send_bits(input logic [53:0] bits, input int first, input int last,
                             input int max_gap);
        for (int b = first; b <= last; b++) begin
            repeat ($urandom_range(max_gap, 0)) @(negedge clk_6M);
            strobe(bits[b]);
        end
    endtask

    // Returns clocks from last strobe to hdr_done_p (-1 if it never came)
    task automatic finish_hdr(output int lat);
        lat = -1;
        for (int c = 1; c <= 6 && lat < 0; c++) begin
            @(negedge clk_6M);
            if (hdr_done_p) lat = c;
        end
    endtask

    task automatic check_outs(input string tag, input logic [9:0] ef, input logic eg,
                              input logic [4:0] ee, input int lat);
        chk({tag, " latency"}, 32'(lat), 32'd2);
        chk({tag, " fields"}, 32'({hdr_seqn, hdr_arqn, hdr_flow, hdr_type, hdr_lt_addr}), 32'(ef));
        chk({tag, " hec_good"}, 32'(hec_good), 32'(eg));
        chk({tag, " errcnt"}, 32'(fec13_errcnt), 32'(ee));
    endtask

    typedef struct {
        logic [53:0] bits;
        logic [6:0]  wini;
        logic        mpr, spr, ir;
        logic [9:0]  exp_fields;
        logic        exp_good;
        logic [4:0]  exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vec_t        v;
        logic [53:0] bits;
        logic [9:0]  base_data, ef;
        logic        eg;
        logic [4:0]  ee;
        logic [6:0]  wi;
        logic        m, s, i;
        int          lat, cnt0;

        rstz = 1'b0; p_1us = 1'b0; rxbit = 1'b0; hdr_st_p = 1'b0;
        whiten_ini = 7'd0; mpr = 1'b0; spr = 1'b0; ir = 1'b0;

        // ---- vector table ----
        // 1: all-zero header, zero seeds
        v = '{bits: '0, wini: 7'd0, mpr: 1'b0, spr: 1'b0, ir: 1'b1,
              exp_fields: 10'd0, exp_good: 1'b1, exp_err: 5'd0};
        vecs.push_back(v);
        // 2: one bit of every triplet flipped to 1
        bits = '0;
        for (int k = 0; k < 18; k++) bits[3*k + (k % 3)] = 1'b1;
        v.bits = bits;
`ifdef HDR_FEC13_ERRCNT_EN
        v.exp_err = 5'd18;
`endif
        vecs.push_back(v);
        // 3: first triplet 1,1,0 -> info bit 0 set, HEC fails
        v.bits = 54'b011;
        v.exp_fields = 10'b0000000001; v.exp_good = 1'b0;
`ifdef HDR_FEC13_ERRCNT_EN
        v.exp_err = 5'd1;
`endif
        vecs.push_back(v);
        // 4: encoded header, paged UAP 47, whiten 55, SEQN=1 TYPE=A LT_ADDR=5
        base_data = {1'b1, 1'b0, 1'b0, 4'hA, 3'd5};
        v = '{bits: encode(base_data, 7'h55, UAP_PAGED), wini: 7'h55, mpr: 1'b1,
              spr: 1'b0, ir: 1'b0, exp_fields: base_data, exp_good: 1'b1, exp_err: 5'd0};
        vecs.push_back(v);
        // 4b: every single info-bit flip must break the HEC
        for (int k = 0; k < 18; k++) begin
            vec_t f;
            f = v;
            f.bits = v.bits ^ (54'h7 << (3 * k));
            if (k < 10) f.exp_fields = base_data ^ (10'd1 << k);
            f.exp_good = 1'b0;
            vecs.push_back(f);
        end

        // ---- reset state ----
        repeat (3) @(negedge clk_6M);
        chk("reset fields", 32'({hdr_seqn, hdr_arqn, hdr_flow, hdr_type, hdr_lt_addr}), 32'd0);
        chk("reset hec_good", 32'(hec_good), 32'd0);
        chk("reset done/busy", 32'({hdr_done_p, hdr_busy}), 32'd0);
        chk("reset errcnt", 32'(fec13_errcnt), 32'd0);
        rstz = 1'b1;
        @(negedge clk_6M);

        // ---- table ----
        foreach (vecs[n]) begin
            start_hdr(vecs[n].wini, vecs[n].mpr, vecs[n].spr, vecs[n].ir, 1'b0);
            send_bits(vecs[n].bits, 0, 53, n % 4);
            finish_hdr(lat);
            check_outs($sformatf("vec%0d", n), vecs[n].exp_fields, vecs[n].exp_good,
                       vecs[n].exp_err, lat);
        end

        // ---- randomized headers against the model ----
        for (int n = 0; n < 40; n++) begin
            wi = 7'($urandom); m = 1'($urandom); s = 1'($urandom); i = 1'($urandom);
            if ($urandom_range(3, 0) != 0) begin
                bits = encode(10'($urandom), wi, hec_seed(m, s, i));
                for (int k = 0; k < 18; k++)
                    if ($urandom_range(3, 0) == 0) bits[3*k + $urandom_range(2, 0)] ^= 1'b1;
            end else begin
                bits = {22'($urandom), 32'($urandom)};
            end
            model_decode(bits, wi, hec_seed(m, s, i), ef, eg, ee);
            start_hdr(wi, m, s, i, 1'b0);
            send_bits(bits, 0, 53, 3);
            finish_hdr(lat);
            check_outs($sformatf("rnd%0d", n), ef, eg, ee, lat);
        end

        // ---- abort after 20 strobes, then a full header ----
        start_hdr(7'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(vecs[3].bits, 0, 53, 1);
        finish_hdr(lat);
        check_outs("abort pre", base_data, 1'b1, 5'd0, lat);
        repeat (2) @(negedge clk_6M);
        cnt0 = done_cnt;
        bits = encode(10'h2C6, 7'h12, UAP_MASTER);
        start_hdr(7'h3B, 1'b0, 1'b1, 1'b0, 1'b0);
        send_bits(encode(10'h155, 7'h3B, UAP_MY), 0, 19, 2);
        chk("abort busy", 32'(hdr_busy), 32'd1);
        chk("abort hold", 32'({hec_good, hdr_seqn, hdr_arqn, hdr_flow, hdr_type, hdr_lt_addr}),
            32'({1'b1, base_data}));
        start_hdr(7'h12, 1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(bits, 0, 53, 2);
        finish_hdr(lat);
        check_outs("abort post", 10'h2C6, 1'b1, 5'd0, lat);
        repeat (3) @(negedge clk_6M);
        chk("abort done count", 32'(done_cnt - cnt0), 32'd1);
        chk("idle busy", 32'(hdr_busy), 32'd0);

        // ---- async reset after 30 strobes ----
        cnt0 = done_cnt;
        bits = encode(10'h3E7, 7'h6A, 8'h00);
        start_hdr(7'h6A, 1'b0, 1'b0, 1'b1, 1'b0);
        send_bits(bits, 0, 29, 2);
        #2 rstz = 1'b0;
        #1;
        chk("rst mid fields", 32'({hdr_seqn, hdr_arqn, hdr_flow, hdr_type, hdr_lt_addr}), 32'd0);
        chk("rst mid flags", 32'({hec_good, hdr_done_p, hdr_busy, fec13_errcnt}), 32'd0);
        repeat (3) @(negedge clk_6M);
        rstz = 1'b1;
        repeat (4) @(negedge clk_6M);
        chk("rst no done", 32'(done_cnt - cnt0), 32'd0);
        start_hdr(7'h6A, 1'b0, 1'b0, 1'b1, 1'b0);
        send_bits(bits, 0, 53, 1);
        finish_hdr(lat);
        check_outs("rst post", 10'h3E7, 1'b1, 5'd0, lat);

        // ---- start and strobe in the same cycle: the strobe is dropped ----
        repeat (2) strobe(1'b1);
        bits = encode(10'h0B9, 7'h21, UAP_PAGED);
        start_hdr(7'h21, 1'b1, 1'b1, 1'b1, 1'b1);
        send_bits(bits, 0, 53, 0);
        finish_hdr(lat);
        check_outs("collide", 10'h0B9, 1'b1, 5'd0, lat);
        @(negedge clk_6M);
        chk("done width", 32'(hdr_done_p), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
